// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package control;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [0:0] {
    RUN,
    DROP
  } pipe_ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the ID instruction reads a register that the EX load has not produced yet.
module hazard_detect
  import control::*;
(
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  output logic                  lu
);

  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is never written, so a load to x0 cannot create a dependency.
    lu      = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: register enables, bubbles, squashes,
// wrong-path fetch tracking and saturating stall/flush counters.
module pipeline_ctrl
  import control::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_busy,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  input  logic                  mispredict,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  output logic                  load_pc,
  output logic                  load_if_id,
  output logic                  load_id_ex,
  output logic                  load_ex_mem,
  output logic                  load_mem_wb,
  output logic                  bubble_id_ex,
  output logic                  squash_if_id,
  output logic                  drop_fetch,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  pipe_ctrl_state_e state_q, state_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic lu, dstall, istall, stall_inc, flush_inc;

  hazard_detect u_hazard_detect (
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .lu          (lu)
  );

  assign dstall    = dmem_req & ~dmem_resp;
  assign istall    = ~imem_resp;
  assign stall_inc = dstall | lu | istall | (state_q == DROP);
  // A mispredict under a data stall re-presents once EX unfreezes, so it is not counted here.
  assign flush_inc = mispredict & ~dstall;

  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    bubble_id_ex = 1'b0;
    squash_if_id = 1'b0;
    drop_fetch   = 1'b0;
    state_d      = state_q;
    if (rst) begin
      if (dstall) begin
        // The frozen pipeline does not stop the wrong-path response from arriving.
        if (state_q == DROP && imem_resp) begin
          drop_fetch = 1'b1;
          state_d    = RUN;
        end
      end else begin
        unique case (state_q)
          RUN: begin
            if (mispredict) begin
              load_pc      = 1'b1;
              load_if_id   = 1'b1;
              squash_if_id = 1'b1;
              load_id_ex   = 1'b1;
              bubble_id_ex = 1'b1;
              load_ex_mem  = 1'b1;
              load_mem_wb  = 1'b1;
              drop_fetch   = imem_resp;
              if (imem_busy && !imem_resp) state_d = DROP;
            end else if (lu || istall) begin
              load_id_ex   = 1'b1;
              bubble_id_ex = 1'b1;
              load_ex_mem  = 1'b1;
              load_mem_wb  = 1'b1;
            end else begin
              load_pc      = 1'b1;
              load_if_id   = 1'b1;
              load_id_ex   = 1'b1;
              load_ex_mem  = 1'b1;
              load_mem_wb  = 1'b1;
            end
          end
          DROP: begin
            load_pc      = mispredict;
            load_id_ex   = 1'b1;
            bubble_id_ex = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            drop_fetch   = imem_resp;
            if (!mispredict && imem_resp) state_d = RUN;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a behavioural model checked every cycle plus literal pins.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       imem_busy;
    logic       imem_resp;
    logic       dmem_req;
    logic       dmem_resp;
    logic       mispredict;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
  } in_t;

  logic clk, rst, drv_rst;
  in_t  vin;

  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic bubble_id_ex, squash_if_id, drop_fetch;
  logic [31:0] stall_cycles, flush_count;
  logic s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
  logic s_bubble, s_squash, s_drop;
  logic [2:0] s_stall, s_flush;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: whether a wrong-path fetch is outstanding, and unbounded event counts.
  logic   m_drop;
  longint m_stall, m_flush;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_busy    (vin.imem_busy),
    .imem_resp    (vin.imem_resp),
    .dmem_req     (vin.dmem_req),
    .dmem_resp    (vin.dmem_resp),
    .mispredict   (vin.mispredict),
    .ex_is_load   (vin.ex_is_load),
    .ex_rd        (vin.ex_rd),
    .id_rs1       (vin.id_rs1),
    .id_rs2       (vin.id_rs2),
    .id_uses_rs1  (vin.id_uses_rs1),
    .id_uses_rs2  (vin.id_uses_rs2),
    .load_pc      (load_pc),
    .load_if_id   (load_if_id),
    .load_id_ex   (load_id_ex),
    .load_ex_mem  (load_ex_mem),
    .load_mem_wb  (load_mem_wb),
    .bubble_id_ex (bubble_id_ex),
    .squash_if_id (squash_if_id),
    .drop_fetch   (drop_fetch),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  // Narrow-counter instance exercises saturation.
  pipeline_ctrl #(.CNT_W(3)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .imem_busy    (vin.imem_busy),
    .imem_resp    (vin.imem_resp),
    .dmem_req     (vin.dmem_req),
    .dmem_resp    (vin.dmem_resp),
    .mispredict   (vin.mispredict),
    .ex_is_load   (vin.ex_is_load),
    .ex_rd        (vin.ex_rd),
    .id_rs1       (vin.id_rs1),
    .id_rs2       (vin.id_rs2),
    .id_uses_rs1  (vin.id_uses_rs1),
    .id_uses_rs2  (vin.id_uses_rs2),
    .load_pc      (s_load_pc),
    .load_if_id   (s_load_if_id),
    .load_id_ex   (s_load_id_ex),
    .load_ex_mem  (s_load_ex_mem),
    .load_mem_wb  (s_load_mem_wb),
    .bubble_id_ex (s_bubble),
    .squash_if_id (s_squash),
    .drop_fetch   (s_drop),
    .stall_cycles (s_stall),
    .flush_count  (s_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.imem_resp = 1'b1;
    return v;
  endfunction

  function automatic logic m_lu(input in_t v);
    return v.ex_is_load && v.ex_rd != 5'd0 &&
           ((v.id_uses_rs1 && v.id_rs1 == v.ex_rd) || (v.id_uses_rs2 && v.id_rs2 == v.ex_rd));
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble, squash, drop}
  function automatic logic [7:0] exp_ctrl(input in_t v, input logic r, input logic dropping);
    logic dst;
    dst = v.dmem_req & ~v.dmem_resp;
    if (!r) return 8'b0;
    if (dst) return {7'b0, dropping & v.imem_resp};
    if (dropping) return {v.mispredict, 6'b011110, v.imem_resp};
    if (v.mispredict) return {7'b1111111, v.imem_resp};
    if (m_lu(v) || !v.imem_resp) return 8'b00111100;
    return 8'b11111000;
  endfunction

  task automatic model_tick();
    logic dst, mp;
    if (rst) begin
      dst = vin.dmem_req & ~vin.dmem_resp;
      mp  = vin.mispredict & ~dst;
      if (dst || m_lu(vin) || !vin.imem_resp || m_drop) m_stall++;
      if (mp) m_flush++;
      m_drop = m_drop ? (mp | ~vin.imem_resp) : (mp & vin.imem_busy & ~vin.imem_resp);
    end
  endtask

  task automatic check_model();
    chk("ctrl", 64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                     bubble_id_ex, squash_if_id, drop_fetch}), 64'(exp_ctrl(vin, rst, m_drop)));
    chk("ctrl_small", 64'({s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb,
                           s_bubble, s_squash, s_drop}), 64'(exp_ctrl(vin, rst, m_drop)));
    chk("stall_cycles", 64'(stall_cycles), 64'(sat(m_stall, 64'hFFFF_FFFF)));
    chk("flush_count", 64'(flush_count), 64'(sat(m_flush, 64'hFFFF_FFFF)));
    chk("stall_small", 64'(s_stall), 64'(sat(m_stall, 7)));
    chk("flush_small", 64'(s_flush), 64'(sat(m_flush, 7)));
  endtask

  // One cycle: advance model at the edge, apply new inputs, check before the falling edge.
  task automatic cyc(input in_t v);
    @(posedge clk);
    model_tick();
    #1;
    rst = drv_rst;
    vin = v;
    #3;
    check_model();
  endtask

  in_t v;

  initial begin
    rst     = 1'b0;
    drv_rst = 1'b0;
    vin     = idle();
    m_drop  = 1'b0;
    m_stall = 0;
    m_flush = 0;
    #2;
    chk("reset_load_pc", 64'(load_pc), 64'd0);
    chk("reset_stall", 64'(stall_cycles), 64'd0);
    cyc(idle());
    drv_rst = 1'b1;

    // No hazards.
    for (int i = 0; i < 10; i++) cyc(idle());
    chk("nohaz_loads", 64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 64'h1F);
    chk("nohaz_stall", 64'(stall_cycles), 64'd0);

    // Load-use on rs1, one cycle.
    v = idle(); v.ex_is_load = 1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.id_uses_rs1 = 1;
    cyc(v);
    chk("lu_load_pc", 64'({load_pc, load_if_id}), 64'd0);
    chk("lu_bubble", 64'(bubble_id_ex), 64'd1);
    cyc(idle());
    chk("lu_stall_cnt", 64'(stall_cycles), 64'd1);
    v.ex_rd = 5'd0; v.id_rs1 = 5'd0;
    cyc(v);
    chk("lu_x0_load_pc", 64'(load_pc), 64'd1);
    // rs2 match, then rs2 match without use.
    v = idle(); v.ex_is_load = 1; v.ex_rd = 5'd7; v.id_rs2 = 5'd7; v.id_uses_rs2 = 1;
    cyc(v);
    chk("lu_rs2_bubble", 64'(bubble_id_ex), 64'd1);
    v.id_uses_rs2 = 0;
    cyc(v);
    chk("lu_rs2_unused", 64'(bubble_id_ex), 64'd0);

    // Data wait with a pending mispredict.
    v = idle(); v.dmem_req = 1; v.mispredict = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(v);
      chk("dwait_loads", 64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}), 64'd0);
    end
    chk("dwait_flush", 64'(flush_count), 64'd0);
    v.dmem_resp = 1;
    cyc(v);
    chk("dwait_release_pc", 64'(load_pc), 64'd1);
    cyc(idle());
    chk("dwait_flush_done", 64'(flush_count), 64'd1);

    // Plain instruction-fetch stall, then dstall combined with load-use.
    v = idle(); v.imem_resp = 0;
    cyc(v);
    cyc(v);
    v = idle(); v.dmem_req = 1; v.ex_is_load = 1; v.ex_rd = 5'd3; v.id_rs1 = 5'd3;
    v.id_uses_rs1 = 1;
    cyc(v);

    // Mispredict with fetch outstanding.
    v = idle(); v.mispredict = 1; v.imem_busy = 1; v.imem_resp = 0;
    cyc(v);
    chk("mp_drop_ctrl", 64'({load_pc, squash_if_id, bubble_id_ex}), 64'h7);
    v.mispredict = 0;
    cyc(v);
    chk("drop_hold_pc", 64'(load_pc), 64'd0);
    v = idle();
    cyc(v);
    chk("drop_fetch", 64'(drop_fetch), 64'd1);
    cyc(idle());
    chk("drop_back_run", 64'({load_pc, drop_fetch}), 64'h2);

    // Mispredict with same-cycle response.
    v = idle(); v.mispredict = 1;
    cyc(v);
    chk("mp_same_drop", 64'(drop_fetch), 64'd1);
    cyc(idle());
    chk("mp_same_run", 64'(load_if_id), 64'd1);

    // Mispredict while dropping: redirect and stay.
    v = idle(); v.mispredict = 1; v.imem_busy = 1; v.imem_resp = 0;
    cyc(v);
    cyc(v);
    v.mispredict = 0;
    cyc(v);
    cyc(idle());
    cyc(idle());

    // Reset mid-drop.
    v = idle(); v.mispredict = 1; v.imem_busy = 1; v.imem_resp = 0;
    cyc(v);
    v.mispredict = 0;
    cyc(v);
    #2;
    rst     = 1'b0;
    drv_rst = 1'b0;
    vin     = idle();
    m_drop  = 1'b0;
    m_stall = 0;
    m_flush = 0;
    #1;
    chk("rst_async_ctrl", 64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                               bubble_id_ex, squash_if_id, drop_fetch}), 64'd0);
    chk("rst_async_cnt", 64'({stall_cycles, flush_count}), 64'd0);
    cyc(idle());
    drv_rst = 1'b1;
    cyc(idle());
    chk("rst_release_run", 64'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                                drop_fetch}), 64'h3E);

    // Counter saturation on the narrow instance.
    v = idle(); v.mispredict = 1;
    for (int i = 0; i < 9; i++) cyc(v);
    v = idle(); v.imem_resp = 0;
    for (int i = 0; i < 9; i++) cyc(v);
    cyc(idle());
    chk("sat_small", 64'({s_stall, s_flush}), 64'h3F);
    chk("sat_big", 64'({stall_cycles, flush_count}), {32'd9, 32'd9});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage RV32I pipeline. It decides every cycle which pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) load, which take a bubble, and which are squashed. It arbitrates among four hazard sources: data-memory wait, branch mispredict, load-use, and instruction-memory wait. It also tracks wrong-path fetches that must be discarded, and keeps stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset. One clock domain; reset is asynchronous and active-low.
- imem_busy  in  1  instruction fetch issued, response not yet returned.
- imem_resp  in  1  instruction fetch data valid this cycle.
- dmem_req  in  1  MEM stage holds a load or store.
- dmem_resp  in  1  data access completes this cycle.
- mispredict  in  1  EX-resolved control flow differs from the prediction.
- ex_is_load  in  1  ID/EX holds a load.
- ex_rd  in  5  destination register of the ID/EX instruction.
- id_rs1, id_rs2  in  5 each  source registers of the IF/ID instruction.
- id_uses_rs1, id_uses_rs2  in  1 each  source register is actually read.
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables.
- bubble_id_ex  out  1  ID/EX loads a NOP instead of the ID contents.
- squash_if_id  out  1  IF/ID loads a NOP.
- drop_fetch  out  1  the current imem_resp is wrong-path and must be discarded.
- stall_cycles  out  CNT_W  cycles in which any stall was applied.
- flush_count  out  CNT_W  mispredicts serviced.

## Operation
Hazard terms:
- dstall = dmem_req & ~dmem_resp.
- istall = ~imem_resp.
- lu = ex_is_load & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).

State machine, two states:
- RUN: normal operation.
- DROP: a wrong-path fetch is still outstanding.

Priority is dstall > mispredict > lu > istall.
- **dstall:** all load_* = 0 and all bubble/squash = 0; the whole pipeline freezes. A mispredict is ignored, because EX is frozen and the signal re-presents next cycle.
- **mispredict (RUN):**
  - load_pc = 1 (redirect); squash_if_id = 1; bubble_id_ex = 1; EX/MEM and MEM/WB load.
  - If imem_busy & ~imem_resp, go to DROP.
  - If imem_resp is high in the same cycle, assert drop_fetch and stay in RUN.
- **lu:** load_pc = load_if_id = 0; bubble_id_ex = 1; the downstream registers load.
- **istall (RUN):** load_pc = load_if_id = 0; bubble_id_ex = 1; the downstream registers load.
- **No hazard:** all load_* = 1; bubble and squash = 0.
- **DROP:**
  - load_pc = load_if_id = 0; bubble_id_ex = 1; downstream registers load unless dstall.
  - On imem_resp: drop_fetch = 1, then return to RUN.
  - A mispredict in DROP reloads the PC (load_pc = 1) and stays in DROP.
- **stall_cycles:** increments on any cycle with dstall, lu, istall, or the DROP state. It saturates at all-ones.
- **flush_count:** increments on every serviced mispredict (one not blocked by dstall). It saturates at all-ones.

## Timing
- All load, bubble, squash and drop outputs are combinational from the inputs and the state, with zero latency.
- The state and both counters are registered and update on the rising clk edge.
- Asynchronous reset (rst low):
  - State goes to RUN and both counters go to 0.
  - While rst is low, all load_*, bubble_id_ex, squash_if_id and drop_fetch are forced to 0.
- The first cycle after rst deasserts behaves as RUN.
- Reset asserted in DROP abandons the drop; the memory side is also reset.
- A load-use hazard persists exactly one cycle, because the load moves to MEM and lu falls.
- A mispredict costs 2 bubbles in RUN, plus the remaining fetch latency in DROP.

## Structure
- The state typedef `pipe_ctrl_state_e` {RUN, DROP} belongs in package `control`.
- One sub-module: `hazard_detect`, a combinational load-use comparator that produces lu.

## Test plan
- **No hazards:** imem_resp = 1, dmem_req = 0, mispredict = 0 for 10 cycles -> all load_* = 1, no bubble, stall_cycles = 0.
- **Load-use:** ex_is_load = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> load_pc = load_if_id = 0, bubble_id_ex = 1 for one cycle, stall_cycles = 1. Repeat with ex_rd = 0 -> no stall.
- **Data wait:** dmem_req = 1 with dmem_resp low for 3 cycles and mispredict = 1 -> all load_* = 0 for 3 cycles and flush_count unchanged. On dmem_resp, flush is serviced -> flush_count = 1.
- **Mispredict with fetch outstanding:** mispredict with imem_busy = 1, imem_resp = 0 -> load_pc = 1, squash_if_id = 1, bubble_id_ex = 1, state DROP. Then imem_resp after 2 cycles -> drop_fetch = 1 on that cycle, RUN on the next.
- **Mispredict with same-cycle response:** mispredict with imem_resp = 1 -> drop_fetch = 1, state stays RUN.
- **Reset mid-DROP:** rst low mid-DROP -> outputs 0 immediately (asynchronous), counters 0. After release -> RUN with all load_* = 1 when no hazard.
